axi_dram_engine: RTL and testbench

Memory-side burst engine of the simulation DRAM model: sits directly downstream of the synchronous AXI slave interface. It drains that interface's write-address, write-data and read-address FIFOs, expands each AXI burst into per-beat accesses on a single-port word memory, and produces read-data FIFO entries and write responses. One burst is in service at a time; reads and writes are arbitrated round-robin.

---
 rtl/axi_dram_pkg.sv | 45 ++++
 rtl/axi_burst_addr_gen.sv | 57 +++++
 rtl/axi_dram_engine.sv | 174 +++++++++++++++++
 tb/tb_axi_dram_engine.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_dram_pkg.sv
// Shared constants, FIFO field offsets and FSM state type for the DRAM model burst engine.
// Field offsets describe the packed {ID, LEN, SIZE, BURST, ADDR} and {ID, STRB, LAST, DATA} FIFO words.
package axi_dram_pkg;

    localparam int A_W     = 32;
    localparam int ID_W    = 4;
    localparam int LEN_W   = 4;
    localparam int DATA_W  = 64;
    localparam int STRB_W  = DATA_W / 8;
    localparam int MEM_AW  = 16;
    localparam int BYTE_SH = $clog2(STRB_W);

    localparam int CMD_W = ID_W + A_W + LEN_W + 5;
    localparam int WD_W  = ID_W + DATA_W + 1 + STRB_W;
    localparam int RD_W  = ID_W + DATA_W + 3;
    localparam int B_W   = ID_W + 2;

    localparam int CMD_ADDR_LSB  = 0;
    localparam int CMD_BURST_LSB = A_W;
    localparam int CMD_SIZE_LSB  = A_W + 2;
    localparam int CMD_LEN_LSB   = A_W + 5;
    localparam int CMD_ID_LSB    = A_W + 5 + LEN_W;

    localparam int WD_DATA_LSB = 0;
    localparam int WD_LAST_BIT = DATA_W;
    localparam int WD_STRB_LSB = DATA_W + 1;
    localparam int WD_ID_LSB   = DATA_W + 1 + STRB_W;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_CMD,
        WR_BEAT,
        WR_RESP,
        RD_BEAT,
        RD_DRAIN
    } state_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Per-beat AXI address sequencer: loaded with {ADDR, LEN, SIZE, BURST}, steps once per advance.
// last is high while the current address belongs to the final beat of the burst.
module axi_burst_addr_gen
    import axi_dram_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [A_W-1:0]   addr_in,
    input  logic [LEN_W-1:0] len_in,
    input  logic [2:0]       size_in,
    input  logic [1:0]       burst_in,
    input  logic             advance,
    output logic [A_W-1:0]   addr,
    output logic             last
);

    logic [A_W-1:0]   addr_q;
    logic [A_W-1:0]   inc_q;
    logic [A_W-1:0]   mask_q;
    logic [LEN_W-1:0] cnt_q;
    logic [1:0]       burst_q;
    logic [A_W-1:0]   nxt_addr;

    always_comb begin
        nxt_addr = addr_q + inc_q;
        case (burst_q)
            BURST_FIXED: nxt_addr = addr_q;
            // wrap windows are always a power of two (2/4/8/16 beats), so a mask suffices
            BURST_WRAP:  nxt_addr = (addr_q & ~mask_q) | ((addr_q + inc_q) & mask_q);
            default:     nxt_addr = addr_q + inc_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            inc_q   <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            burst_q <= BURST_FIXED;
        end else if (load) begin
            addr_q  <= addr_in;
            inc_q   <= A_W'(1) << size_in;
            mask_q  <= ((A_W'(len_in) + A_W'(1)) << size_in) - A_W'(1);
            cnt_q   <= len_in;
            burst_q <= burst_in;
        end else if (advance) begin
            addr_q <= nxt_addr;
            cnt_q  <= cnt_q - LEN_W'(1);
        end
    end

    assign addr = addr_q;
    assign last = (cnt_q == '0);

endmodule

// File: rtl/axi_dram_engine.sv
// Burst engine behind the AXI slave FIFOs: one burst at a time, round-robin read/write, per-beat memory access.
// Optional AXI_DRAM_ENGINE_RESP_CHECK_EN adds SLVERR for bad WLAST / out-of-range beats.
module axi_dram_engine
    import axi_dram_pkg::*;
(
    input  logic              ACLK,
    input  logic              ARESET,
    output logic              awfifo_pop,
    input  logic              awfifo_empty,
    input  logic [CMD_W-1:0]  awfifo_do,
    output logic              wdfifo_pop,
    input  logic              wdfifo_empty,
    input  logic [WD_W-1:0]   wdfifo_do,
    output logic              bfifo_push,
    output logic [B_W-1:0]    bfifo_di,
    input  logic              b_ready,
    output logic              arfifo_pop,
    input  logic              arfifo_empty,
    input  logic [CMD_W-1:0]  arfifo_do,
    output logic              rdfifo_push,
    output logic [RD_W-1:0]   rdfifo_di,
    input  logic              rdfifo_full,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state, nxt;
    logic              last_rd;
    logic [ID_W-1:0]   cmd_id;
    logic              wr_err;
    logic              grant_wr, gen_load, gen_adv, wr_beat, issue;
    logic [CMD_W-1:0]  cmd_sel;
    logic [A_W-1:0]    cur_addr;
    logic              gen_last;
    logic              beat_oor, last_bad;
    logic              pend_vld, pend_last, pend_zero;
    logic [1:0]        pend_resp;
    logic              hold_vld;
    logic [RD_W-1:0]   hold_dat, rd_word;
    logic              unused_bits;

    assign cmd_sel = grant_wr ? awfifo_do : arfifo_do;

    axi_burst_addr_gen u_addr_gen (
        .clk      (ACLK),
        .rst      (ARESET),
        .load     (gen_load),
        .addr_in  (cmd_sel[CMD_ADDR_LSB +: A_W]),
        .len_in   (cmd_sel[CMD_LEN_LSB +: LEN_W]),
        .size_in  (cmd_sel[CMD_SIZE_LSB +: 3]),
        .burst_in (cmd_sel[CMD_BURST_LSB +: 2]),
        .advance  (gen_adv),
        .addr     (cur_addr),
        .last     (gen_last)
    );

`ifdef AXI_DRAM_ENGINE_RESP_CHECK_EN
    assign beat_oor = |cur_addr[A_W-1:MEM_AW+BYTE_SH];
    assign last_bad = wdfifo_do[WD_LAST_BIT] != gen_last;
`else
    assign beat_oor = 1'b0;
    assign last_bad = 1'b0;
`endif

    always_comb begin
        nxt        = state;
        awfifo_pop = 1'b0;
        arfifo_pop = 1'b0;
        wdfifo_pop = 1'b0;
        bfifo_push = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        gen_load   = 1'b0;
        gen_adv    = 1'b0;
        grant_wr   = 1'b0;
        wr_beat    = 1'b0;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (!awfifo_empty && (arfifo_empty || last_rd)) begin
                    awfifo_pop = 1'b1;
                    grant_wr   = 1'b1;
                    gen_load   = 1'b1;
                    nxt        = WR_CMD;
                end else if (!arfifo_empty) begin
                    arfifo_pop = 1'b1;
                    gen_load   = 1'b1;
                    nxt        = RD_BEAT;
                end
            end
            // WR_CMD is a write burst still waiting for its first data beat
            WR_CMD, WR_BEAT: begin
                if (!wdfifo_empty) begin
                    wdfifo_pop = 1'b1;
                    wr_beat    = 1'b1;
                    mem_en     = !beat_oor;
                    mem_we     = !beat_oor;
                    gen_adv    = 1'b1;
                    nxt        = gen_last ? WR_RESP : WR_BEAT;
                end
            end
            WR_RESP: begin
                bfifo_push = 1'b1;
                if (b_ready) nxt = IDLE;
            end
            RD_BEAT: begin
                if (!hold_vld && !(pend_vld && rdfifo_full)) begin
                    issue   = 1'b1;
                    mem_en  = !beat_oor;
                    gen_adv = 1'b1;
                    if (gen_last) nxt = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                if (!((hold_vld || pend_vld) && rdfifo_full)) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    assign rd_word = {cmd_id, pend_last, pend_resp, pend_zero ? {DATA_W{1'b0}} : mem_rdata};

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state     <= IDLE;
            last_rd   <= 1'b1;
            cmd_id    <= '0;
            wr_err    <= 1'b0;
            pend_vld  <= 1'b0;
            pend_last <= 1'b0;
            pend_zero <= 1'b0;
            pend_resp <= RESP_OKAY;
            hold_vld  <= 1'b0;
            hold_dat  <= '0;
        end else begin
            state <= nxt;
            if (gen_load) begin
                last_rd <= !grant_wr;
                cmd_id  <= cmd_sel[CMD_ID_LSB +: ID_W];
                wr_err  <= 1'b0;
            end else if (wr_beat && (beat_oor || last_bad)) begin
                wr_err <= 1'b1;
            end
            pend_vld <= issue;
            if (issue) begin
                pend_last <= gen_last;
                pend_zero <= beat_oor;
                pend_resp <= beat_oor ? RESP_SLVERR : RESP_OKAY;
            end
            // a beat returning into a full FIFO parks here; issue stalls until it drains
            if (hold_vld && !rdfifo_full) begin
                hold_vld <= 1'b0;
            end else if (pend_vld && rdfifo_full) begin
                hold_vld <= 1'b1;
                hold_dat <= rd_word;
            end
        end
    end

    assign rdfifo_push = (hold_vld || pend_vld) && !rdfifo_full;
    assign rdfifo_di   = hold_vld ? hold_dat : (pend_vld ? rd_word : '0);
    assign bfifo_di    = bfifo_push ? {cmd_id, wr_err ? RESP_SLVERR : RESP_OKAY} : '0;
    assign mem_addr    = mem_en ? cur_addr[BYTE_SH +: MEM_AW] : '0;
    assign mem_wdata   = mem_we ? wdfifo_do[WD_DATA_LSB +: DATA_W] : '0;
    assign mem_wstrb   = mem_we ? wdfifo_do[WD_STRB_LSB +: STRB_W] : '0;

    assign unused_bits = ^{cur_addr[BYTE_SH-1:0], cur_addr[A_W-1:MEM_AW+BYTE_SH],
                           wdfifo_do[WD_ID_LSB +: ID_W], wdfifo_do[WD_LAST_BIT]};

endmodule

// File: tb/tb_axi_dram_engine.sv
// Scoreboard bench for axi_dram_engine: queue-backed FIFO/memory model driven on the falling edge.
// Expected memory writes, read beats, write responses and grant order are queued at stimulus time.
module tb_axi_dram_engine;
    import axi_dram_pkg::*;

`ifdef AXI_DRAM_ENGINE_RESP_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic              awfifo_pop, wdfifo_pop, arfifo_pop, bfifo_push, rdfifo_push;
    logic              awfifo_empty = 1'b1, wdfifo_empty = 1'b1, arfifo_empty = 1'b1;
    logic [CMD_W-1:0]  awfifo_do = '0, arfifo_do = '0;
    logic [WD_W-1:0]   wdfifo_do = '0;
    logic [B_W-1:0]    bfifo_di;
    logic              b_ready = 1'b1;
    logic [RD_W-1:0]   rdfifo_di;
    logic              rdfifo_full = 1'b0;
    logic              mem_en, mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata = '0;
    logic [STRB_W-1:0] mem_wstrb;

    axi_dram_engine dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .awfifo_pop(awfifo_pop), .awfifo_empty(awfifo_empty), .awfifo_do(awfifo_do),
        .wdfifo_pop(wdfifo_pop), .wdfifo_empty(wdfifo_empty), .wdfifo_do(wdfifo_do),
        .bfifo_push(bfifo_push), .bfifo_di(bfifo_di), .b_ready(b_ready),
        .arfifo_pop(arfifo_pop), .arfifo_empty(arfifo_empty), .arfifo_do(arfifo_do),
        .rdfifo_push(rdfifo_push), .rdfifo_di(rdfifo_di), .rdfifo_full(rdfifo_full),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    always #5 ACLK = ~ACLK;

    logic [CMD_W-1:0] aw_q[$], ar_q[$];
    logic [WD_W-1:0]  w_q[$];
    logic [87:0]      exp_wr[$];
    logic [RD_W-1:0]  exp_rd[$];
    logic [B_W-1:0]   exp_b[$];
    bit               exp_grant[$];
    logic [63:0]      tmem [0:65535];
    logic [63:0]      ref_mem [0:65535];
    int               n_chk = 0;
    int               n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len, input int size,
                                              input logic [1:0] burst, input int idx);
        logic [31:0] a, inc, win, base;
        a   = start;
        inc = 32'd1 << size;
        win = (len + 1) * inc;
        for (int k = 0; k < idx; k++) begin
            if (burst == 2'b10) begin
                base = a - (a % win);
                a    = base + ((a - base + inc) % win);
            end else if (burst != 2'b00) begin
                a = a + inc;
            end
        end
        return a;
    endfunction

    // memory + FIFO model: apply last cycle's DUT actions, refresh inputs, then sample and score
    logic        p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0, p_mwr = 1'b0, p_mrd = 1'b0;
    logic [15:0] p_waddr = '0, p_raddr = '0;
    logic [63:0] p_wdata = '0;
    logic [7:0]  p_wstrb = '0;
    logic        prev_bstall = 1'b0;
    logic [B_W-1:0] prev_bdi = '0;

    always @(negedge ACLK) begin
        if (p_aw && aw_q.size() > 0) void'(aw_q.pop_front());
        if (p_w  && w_q.size()  > 0) void'(w_q.pop_front());
        if (p_ar && ar_q.size() > 0) void'(ar_q.pop_front());
        if (p_mwr)
            for (int b = 0; b < 8; b++)
                if (p_wstrb[b]) tmem[p_waddr][b*8 +: 8] = p_wdata[b*8 +: 8];
        mem_rdata    = p_mrd ? tmem[p_raddr] : 64'h0;
        awfifo_empty = (aw_q.size() == 0);
        awfifo_do    = awfifo_empty ? '0 : aw_q[0];
        wdfifo_empty = (w_q.size() == 0);
        wdfifo_do    = wdfifo_empty ? '0 : w_q[0];
        arfifo_empty = (ar_q.size() == 0);
        arfifo_do    = arfifo_empty ? '0 : ar_q[0];
        #1;
        p_aw = awfifo_pop; p_w = wdfifo_pop; p_ar = arfifo_pop;
        p_mwr = mem_en && mem_we; p_mrd = mem_en && !mem_we;
        p_waddr = mem_addr; p_raddr = mem_addr; p_wdata = mem_wdata; p_wstrb = mem_wstrb;
        if (awfifo_pop || arfifo_pop) begin
            if (exp_grant.size() == 0) chk("grant_unexpected", 1, 0);
            else chk("grant", {awfifo_pop, arfifo_pop}, exp_grant.pop_front() ? 2'b10 : 2'b01);
        end
        if (mem_en && mem_we) begin
            if (exp_wr.size() == 0) chk("mem_wr_unexpected", 1, 0);
            else chk("mem_wr", {mem_addr, mem_wdata, mem_wstrb}, exp_wr.pop_front());
        end
        if (rdfifo_push && rdfifo_full) chk("rd_push_while_full", 1, 0);
        if (rdfifo_push) begin
            if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_beat", rdfifo_di, exp_rd.pop_front());
        end
        if (prev_bstall) begin
            chk("b_hold_push", bfifo_push, 1'b1);
            chk("b_hold_dat", bfifo_di, prev_bdi);
        end
        if (bfifo_push) chk("b_no_new_burst", {awfifo_pop, arfifo_pop}, 2'b00);
        if (bfifo_push && b_ready) begin
            if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
            else chk("bresp", bfifo_di, exp_b.pop_front());
        end
        prev_bstall = bfifo_push && !b_ready;
        prev_bdi    = bfifo_di;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge ACLK);
        #2;
    endtask

    task automatic send_wr(input logic [3:0] id, input logic [31:0] addr, input int len, input int size,
                           input logic [1:0] burst, input bit rs, input int bad);
        logic [31:0] a;
        logic [63:0] d;
        logic [7:0]  s;
        logic [15:0] w;
        logic        lst, oor, err;
        aw_q.push_back({id, 4'(len), 3'(size), burst, addr});
        exp_grant.push_back(1'b1);
        err = 1'b0;
        for (int i = 0; i <= len; i++) begin
            a   = beat_addr(addr, len, size, burst, i);
            w   = a[BYTE_SH +: MEM_AW];
            oor = CHK_EN && (a[31:MEM_AW+BYTE_SH] != 0);
            d   = {$urandom, $urandom};
            s   = rs ? 8'($urandom_range(1, 255)) : 8'hFF;
            lst = (i == len) || (i == bad);
            if (i == bad && CHK_EN) err = 1'b1;
            w_q.push_back({id, s, lst, d});
            if (!oor) begin
                exp_wr.push_back({w, d, s});
                for (int b = 0; b < 8; b++)
                    if (s[b]) ref_mem[w][b*8 +: 8] = d[b*8 +: 8];
            end
            err = err | oor;
        end
        exp_b.push_back({id, err ? 2'b10 : 2'b00});
    endtask

    task automatic send_rd(input logic [3:0] id, input logic [31:0] addr, input int len, input int size,
                           input logic [1:0] burst);
        logic [31:0] a;
        logic [15:0] w;
        logic        oor;
        ar_q.push_back({id, 4'(len), 3'(size), burst, addr});
        exp_grant.push_back(1'b0);
        for (int i = 0; i <= len; i++) begin
            a   = beat_addr(addr, len, size, burst, i);
            w   = a[BYTE_SH +: MEM_AW];
            oor = CHK_EN && (a[31:MEM_AW+BYTE_SH] != 0);
            exp_rd.push_back({id, i == len, oor ? 2'b10 : 2'b00, oor ? 64'h0 : ref_mem[w]});
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_wr.size() + exp_rd.size() + exp_b.size() + exp_grant.size()) != 0 && n < 600) begin
            cyc(1);
            n++;
        end
        chk(tag, 32'(exp_wr.size() + exp_rd.size() + exp_b.size() + exp_grant.size()), 0);
        cyc(2);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            tmem[i]    = {16'hC0DE, 16'(i), 16'(~i), 16'(i * 3)};
            ref_mem[i] = tmem[i];
        end
        cyc(3);
        chk("rst_strobes", {awfifo_pop, wdfifo_pop, arfifo_pop, bfifo_push, rdfifo_push, mem_en, mem_we}, 0);
        chk("rst_mem_bus", {mem_addr, mem_wdata, mem_wstrb}, 0);
        chk("rst_resp_bus", {bfifo_di, rdfifo_di}, 0);
        ARESET = 1'b0;
        cyc(2);
        chk("idle_strobes", {awfifo_pop, wdfifo_pop, arfifo_pop, bfifo_push, rdfifo_push, mem_en, mem_we}, 0);
        chk("idle_buses", {mem_addr, mem_wdata, mem_wstrb, bfifo_di, rdfifo_di}, 0);

        send_wr(4'h3, 32'h100, 3, 3, BURST_INCR, 1'b0, -1);
        drain("drain_incr_wr");
        send_rd(4'h5, 32'h100, 3, 3, BURST_INCR);
        drain("drain_readback");
        send_rd(4'h9, 32'h18, 3, 3, BURST_WRAP);
        drain("drain_wrap_rd");

        send_wr(4'h1, 32'h400, 1, 3, BURST_INCR, 1'b1, -1);
        send_rd(4'h2, 32'h800, 1, 3, BURST_INCR);
        send_wr(4'h3, 32'h444, 2, 2, BURST_FIXED, 1'b1, -1);
        send_rd(4'h4, 32'h1000, 3, 3, 2'b11);
        drain("drain_arbitration");

        send_wr(4'hC, 32'h3014, 7, 2, BURST_WRAP, 1'b1, -1);
        drain("drain_wrap_wr");
        send_rd(4'h6, 32'h2000, 15, 3, BURST_INCR);
        cyc(6);
        rdfifo_full = 1'b1;
        cyc(5);
        rdfifo_full = 1'b0;
        drain("drain_rd_backpressure");

        b_ready = 1'b0;
        send_wr(4'h7, 32'h500, 1, 3, BURST_INCR, 1'b0, -1);
        cyc(2);
        send_rd(4'h8, 32'h600, 0, 3, BURST_INCR);
        cyc(15);
        b_ready = 1'b1;
        drain("drain_b_stall");

        send_wr(4'hA, 32'h700, 3, 3, BURST_INCR, 1'b0, 1);
        send_rd(4'hB, 32'h80000, 0, 3, BURST_INCR);
        drain("drain_resp_check");

        chk("end_fifos_empty", 32'(aw_q.size() + w_q.size() + ar_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
